// File: rtl/spi_master_if.sv
// Host-side word interface of the SPI master: request/accept handshake, receive
// result, status and debug visibility of the controller FSM.
interface spi_master_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int LW = $clog2(DATA_WIDTH + 1);

  // Handshake: a word is taken on any rising clk edge where tx_valid && tx_ready.
  // tx_ready is high only while the controller idles; rx_valid is a one-cycle
  // pulse with no back-pressure, and rx_data holds until the next completion.
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  three_wire;
  logic [LW-1:0]         wr_len;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  busy;
  logic [1:0]            dbg_state;
  logic                  dbg_sdio_oe;

  modport master (
    output tx_data, tx_valid, three_wire, wr_len,
    input  tx_ready, rx_data, rx_valid, busy, dbg_state, dbg_sdio_oe
  );

  modport slave (
    input  tx_data, tx_valid, three_wire, wr_len,
    output tx_ready, rx_data, rx_valid, busy, dbg_state, dbg_sdio_oe
  );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 initiator: one DATA_WIDTH-bit word per transaction, MSB first,
// 4-wire or 3-wire (shared SDIO with write-then-read turnaround).
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic            clk,
  input  logic            rst,
  spi_master_if.slave     bus,
  output logic            scl,
  output logic            cs_n,
  output logic            sdo,
  inout  wire             sdi_sdio
);
  localparam int LW = $clog2(DATA_WIDTH + 1);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t                r_state;
  logic                  r_first;
  logic [CW-1:0]         r_div;
  logic [BW-1:0]         r_bit;
  logic [DATA_WIDTH-1:0] r_tx;
  logic [DATA_WIDTH-1:0] r_rx;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  r_three;
  logic [LW-1:0]         r_wr_len;
  logic                  r_tx_ready;
  logic                  r_busy;
  logic                  r_scl;
  logic                  r_cs_n;
  logic                  r_sdo;
  logic                  r_oe;
  logic                  r_sdio_out;
  logic [LW-1:0]         w_wr_len_c;

  assign w_wr_len_c = (bus.wr_len > LW'(DATA_WIDTH)) ? LW'(DATA_WIDTH) : bus.wr_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_first    <= 1'b0;
      r_div      <= '0;
      r_bit      <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_three    <= 1'b0;
      r_wr_len   <= '0;
      r_tx_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_scl      <= 1'b0;
      r_cs_n     <= 1'b1;
      r_sdo      <= 1'b0;
      r_oe       <= 1'b0;
      r_sdio_out <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.tx_valid) begin
            r_state    <= S_SHIFT;
            r_first    <= 1'b1;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_tx       <= bus.tx_data;
            r_three    <= bus.three_wire;
            r_wr_len   <= w_wr_len_c;
            r_rx       <= '0;
          end
        end
        S_SHIFT: begin
          if (r_first) begin
            // Select the slave and present the MSB one cycle after accept.
            r_first <= 1'b0;
            r_cs_n  <= 1'b0;
            r_div   <= '0;
            r_bit   <= '0;
            if (r_three) begin
              r_sdo      <= 1'b0;
              r_oe       <= (r_wr_len != '0);
              r_sdio_out <= r_tx[DATA_WIDTH-1];
            end else begin
              r_sdo <= r_tx[DATA_WIDTH-1];
            end
          end else if (r_div == DIV_LAST) begin
            r_div <= '0;
            if (!r_scl) begin
              r_scl <= 1'b1;
              r_rx  <= {r_rx[DATA_WIDTH-2:0], sdi_sdio};
            end else begin
              r_scl <= 1'b0;
              if (r_bit == BIT_LAST) begin
                r_state <= S_HOLD;
                r_sdo   <= 1'b0;
                r_oe    <= 1'b0;
              end else begin
                // Falling edge ends the current bit and presents the next one.
                r_bit      <= r_bit + BW'(1);
                r_tx       <= {r_tx[DATA_WIDTH-2:0], 1'b0};
                r_sdio_out <= r_tx[DATA_WIDTH-2];
                if (!r_three) r_sdo <= r_tx[DATA_WIDTH-2];
                if ((LW'(r_bit) + LW'(1)) >= r_wr_len) r_oe <= 1'b0;
              end
            end
          end else begin
            r_div <= r_div + CW'(1);
          end
        end
        S_HOLD: begin
          if (r_div == DIV_LAST) begin
            r_div      <= '0;
            r_cs_n     <= 1'b1;
            r_rx_valid <= 1'b1;
            r_rx_data  <= r_rx;
            r_state    <= S_GAP;
          end else begin
            r_div <= r_div + CW'(1);
          end
        end
        S_GAP: begin
          // Minimum deselect time before another word can be accepted.
          if (r_div == DIV_LAST) begin
            r_div      <= '0;
            r_state    <= S_IDLE;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_div <= r_div + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sdi_sdio        = r_oe ? r_sdio_out : 1'bz;
  assign scl             = r_scl;
  assign cs_n            = r_cs_n;
  assign sdo             = r_sdo;
  assign bus.tx_ready    = r_tx_ready;
  assign bus.busy        = r_busy;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.rx_data     = r_rx_data;
  assign bus.dbg_state   = r_state;
  assign bus.dbg_sdio_oe = r_oe;
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: vector table through a loopback/slave model on the
// 2-divider instance, plus reset, back-to-back and divider-1 sequences.
module tb_spi_master;
  localparam int DW = 8;
  localparam int D0 = 2;
  localparam int D1 = 1;

  typedef struct {
    logic       three;
    logic [3:0] wl;
    logic [7:0] tx;
    int         mode;     // 0 none, 1 loopback sdo->sdio, 2 slave drives sdio
    logic [7:0] sw;
    int         ss;       // first bit index the slave drives
    logic [7:0] erx;
    logic [7:0] esdo;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_master_if #(.DATA_WIDTH(DW)) bus0 ();
  spi_master_if #(.DATA_WIDTH(DW)) bus1 ();
  logic scl0, cs_n0, sdo0, scl1, cs_n1, sdo1;
  wire  sdio0, sdio1;

  spi_master #(.DATA_WIDTH(DW), .CLK_DIV(D0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave),
    .scl(scl0), .cs_n(cs_n0), .sdo(sdo0), .sdi_sdio(sdio0)
  );
  spi_master #(.DATA_WIDTH(DW), .CLK_DIV(D1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave),
    .scl(scl1), .cs_n(cs_n1), .sdo(sdo1), .sdi_sdio(sdio1)
  );

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] sdo_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // serial-side model
  int         mode = 0;
  logic [7:0] slave_word = '0;
  int         slave_start = 0;
  int         fall_cnt = 0;
  logic       prev_scl_p = 1'b0;
  logic       tb_en;
  logic       tb_val;
  logic [2:0] sidx;
  assign sdio0 = tb_en ? tb_val : 1'bz;

  always_comb begin
    tb_en  = 1'b0;
    tb_val = 1'b0;
    sidx   = 3'(DW - 1 - fall_cnt);
    if (mode == 1) begin
      tb_en  = 1'b1;
      tb_val = sdo0;
    end else if (mode == 2 && !cs_n0 && fall_cnt >= slave_start && fall_cnt < DW) begin
      tb_en  = 1'b1;
      tb_val = slave_word[sidx];
    end
  end

  int cyc = 0;
  int acc_cyc = 0, acc_cnt = 0, acc1_cyc = 0, acc1_cnt = 0;
  always @(posedge clk) begin
    cyc++;
    if (cs_n0) fall_cnt = 0;
    else if (prev_scl_p && !scl0) fall_cnt++;
    prev_scl_p = scl0;
    if (!rst && bus0.tx_valid && bus0.tx_ready) begin acc_cyc = cyc; acc_cnt++; end
    if (!rst && bus1.tx_valid && bus1.tx_ready) begin acc1_cyc = cyc; acc1_cnt++; end
  end

  // scoreboard / monitor, instance 0
  int   cur_three = 0, cur_wlc = 0;
  int   bits_done = 0, rises = 0, rx_cnt = 0;
  int   rxv_cyc = 0, rdy_cyc = 0, cs_rise_cyc = 0;
  int   gap_chk = 0;
  logic [7:0] sdo_w = '0;
  logic [7:0] e_rx, e_sdo;
  logic prev_cs = 1'b1, prev_scl = 1'b0, prev_rdy = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      prev_cs = 1'b1; prev_scl = 1'b0; prev_rdy = 1'b1;
    end else begin
      chk("proto0_scl_cs_busy", {scl0 & cs_n0, bus0.busy ^ bus0.tx_ready}, 2'b01);
      if (prev_scl) chk("proto0_cs_stable", cs_n0, prev_cs);
      if (prev_cs && !cs_n0) begin
        chk("cs_fall_time", cyc, acc_cyc + 1);
        bits_done = 0; rises = 0; sdo_w = '0;
        if (gap_chk != 0) begin
          chk("btb_cs_gap", cyc - cs_rise_cyc, 2 * D0);
          gap_chk = 0;
        end
      end
      if (!prev_scl && scl0) begin
        rises++;
        sdo_w = {sdo_w[6:0], sdo0};
        if (rises == 1) chk("first_rise_time", cyc, acc_cyc + 1 + D0);
      end
      if (prev_scl && !scl0) bits_done++;
      if (!cs_n0) chk("sdio_oe", bus0.dbg_sdio_oe, (cur_three != 0) && (bits_done < cur_wlc));
      if (!prev_cs && cs_n0) cs_rise_cyc = cyc;
      if (bus0.rx_valid) begin
        chk("rxv_time", cyc, acc_cyc + 1 + 2 * DW * D0 + D0);
        chk("rxv_cs_high", cs_n0, 1);
        chk("scl_pulses", rises, DW);
        if (exp_q.size() == 0) begin
          chk("rx_unexpected", 1, 0);
        end else begin
          e_rx  = exp_q.pop_front();
          e_sdo = sdo_q.pop_front();
          chk("rx_data", bus0.rx_data, e_rx);
          chk("sdo_bits", sdo_w, e_sdo);
        end
        rxv_cyc = cyc;
        rx_cnt++;
      end
      if (!prev_rdy && bus0.tx_ready) begin
        chk("ready_time", cyc, rxv_cyc + D0);
        rdy_cyc = cyc;
      end
      prev_cs = cs_n0; prev_scl = scl0; prev_rdy = bus0.tx_ready;
    end
  end

  // monitor, divider-1 instance (3-wire, nothing written)
  int   rx1_cnt = 0, last_rise1 = -1;
  logic prev_cs1 = 1'b1, prev_scl1 = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_cs1 = 1'b1; prev_scl1 = 1'b0; last_rise1 = -1;
    end else begin
      chk("proto1_scl_cs_busy_oe", {scl1 & cs_n1, bus1.busy ^ bus1.tx_ready, bus1.dbg_sdio_oe}, 3'b010);
      if (prev_scl1) chk("proto1_cs_stable", cs_n1, prev_cs1);
      if (prev_cs1 && !cs_n1) last_rise1 = -1;
      if (!prev_scl1 && scl1) begin
        if (last_rise1 >= 0) chk("scl1_period", cyc - last_rise1, 2);
        last_rise1 = cyc;
      end
      if (bus1.rx_valid) begin
        chk("rxv1_time", cyc, acc1_cyc + 1 + 2 * DW * D1 + D1);
        rx1_cnt++;
      end
      prev_cs1 = cs_n1; prev_scl1 = scl1;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus0.tx_ready && n < 200) begin tick(); n++; end
    chk("ready_wait", bus0.tx_ready, 1);
  endtask

  task automatic wait_accept(input int a0);
    int n = 0;
    while (acc_cnt == a0 && n < 20) begin tick(); n++; end
    chk("accept", acc_cnt - a0, 1);
  endtask

  task automatic wait_rx(input int r0, input int want);
    int n = 0;
    while (rx_cnt < r0 + want && n < 300) begin tick(); n++; end
    chk("rx_done", rx_cnt - r0, want);
  endtask

  task automatic send0(input logic three, input logic [3:0] wl, input logic [7:0] tx,
                       input logic [7:0] erx, input logic [7:0] esdo);
    int a0, r0;
    wait_ready();
    cur_three = three;
    cur_wlc   = (wl > 4'd8) ? 8 : int'(wl);
    exp_q.push_back(erx);
    sdo_q.push_back(esdo);
    a0 = acc_cnt; r0 = rx_cnt;
    bus0.tx_data = tx; bus0.three_wire = three; bus0.wr_len = wl; bus0.tx_valid = 1'b1;
    wait_accept(a0);
    bus0.tx_valid   = 1'b0;
    bus0.tx_data    = 8'($urandom);
    bus0.three_wire = 1'($urandom);
    bus0.wr_len     = 4'($urandom);
    wait_rx(r0, 1);
  endtask

  function automatic vec_t mk(input logic three, input logic [3:0] wl, input logic [7:0] tx,
                              input int md, input logic [7:0] sw, input int ss,
                              input logic [7:0] erx, input logic [7:0] esdo);
    vec_t v;
    v.three = three; v.wl = wl; v.tx = tx; v.mode = md;
    v.sw = sw; v.ss = ss; v.erx = erx; v.esdo = esdo;
    return v;
  endfunction

  vec_t vecs[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r1, r2, r3, r4;
    int a0, r0, rc, n;
    logic ps;

    rst = 1'b1;
    bus0.tx_valid = 1'b0; bus0.tx_data = '0; bus0.three_wire = 1'b0; bus0.wr_len = '0;
    bus1.tx_valid = 1'b0; bus1.tx_data = '0; bus1.three_wire = 1'b1; bus1.wr_len = '0;
    repeat (3) tick();
    chk("rst_pins", {scl0, cs_n0, sdo0, bus0.dbg_sdio_oe}, 4'b0100);
    chk("rst_status", {bus0.tx_ready, bus0.busy, bus0.rx_valid}, 3'b100);
    chk("rst_rx_data", bus0.rx_data, 0);
    chk("rst_state", bus0.dbg_state, 0);
    rst = 1'b0;
    tick();

    r1 = 8'($urandom_range(0, 255));
    r2 = 8'($urandom_range(0, 255));
    r3 = 8'($urandom_range(0, 255));
    r4 = 8'($urandom_range(0, 255));
    vecs[0] = mk(1'b0, 4'd0,  8'hA5, 1, 8'h00, 0, 8'hA5, 8'hA5);
    vecs[1] = mk(1'b0, 4'd0,  8'hFF, 2, 8'h3C, 0, 8'h3C, 8'hFF);
    vecs[2] = mk(1'b1, 4'd4,  8'hB0, 2, 8'h07, 4, 8'hB7, 8'h00);
    vecs[3] = mk(1'b1, 4'd15, 8'hC3, 0, 8'h00, 0, 8'hC3, 8'h00);
    vecs[4] = mk(1'b1, 4'd0,  8'h11, 2, 8'h96, 0, 8'h96, 8'h00);
    vecs[5] = mk(1'b0, 4'd0,  r1,    1, 8'h00, 0, r1,    r1);
    vecs[6] = mk(1'b1, 4'd8,  r2,    0, 8'h00, 0, r2,    8'h00);
    vecs[7] = mk(1'b1, 4'd2,  r3,    2, r4,    2, {r3[7:6], r4[5:0]}, 8'h00);

    for (int i = 0; i < 8; i++) begin
      mode = vecs[i].mode; slave_word = vecs[i].sw; slave_start = vecs[i].ss;
      send0(vecs[i].three, vecs[i].wl, vecs[i].tx, vecs[i].erx, vecs[i].esdo);
    end

    // back-to-back words with tx_valid held high
    mode = 1;
    wait_ready();
    cur_three = 0; cur_wlc = 0;
    exp_q.push_back(8'h01); sdo_q.push_back(8'h01);
    exp_q.push_back(8'h80); sdo_q.push_back(8'h80);
    a0 = acc_cnt; r0 = rx_cnt;
    bus0.three_wire = 1'b0; bus0.wr_len = '0; bus0.tx_data = 8'h01; bus0.tx_valid = 1'b1;
    wait_accept(a0);
    bus0.tx_data = 8'h80;
    tick(); tick();
    gap_chk = 1;
    n = 0;
    while (acc_cnt == a0 + 1 && n < 100) begin tick(); n++; end
    chk("btb_second_accept", acc_cnt - a0, 2);
    chk("btb_accept_at_ready", acc_cyc, rdy_cyc + 1);
    bus0.tx_valid = 1'b0;
    wait_rx(r0, 2);
    chk("btb_gap_seen", gap_chk, 0);

    // reset on the third scl rising edge
    mode = 1;
    wait_ready();
    cur_three = 0; cur_wlc = 0;
    exp_q.push_back(8'hC6); sdo_q.push_back(8'hC6);
    a0 = acc_cnt;
    bus0.tx_data = 8'hC6; bus0.tx_valid = 1'b1;
    wait_accept(a0);
    bus0.tx_valid = 1'b0;
    rc = 0; n = 0; ps = scl0;
    while (rc < 3 && n < 200) begin
      tick(); n++;
      if (scl0 && !ps) rc++;
      ps = scl0;
    end
    rst = 1'b1;
    chk("rst_at_rise3", rc, 3);
    tick();
    chk("midrst_pins", {cs_n0, scl0, bus0.dbg_sdio_oe}, 3'b100);
    chk("midrst_status", {bus0.tx_ready, bus0.busy, bus0.rx_valid}, 3'b100);
    chk("midrst_rx_data", bus0.rx_data, 0);
    exp_q.delete(); sdo_q.delete();
    tick();
    rst = 1'b0;
    r0 = rx_cnt;
    repeat (60) tick();
    chk("midrst_no_rxv", rx_cnt - r0, 0);
    send0(1'b0, 4'd0, 8'h5A, 8'h5A, 8'h5A);

    // divider 1, 3-wire with no write bits
    for (int k = 0; k < 2; k++) begin
      a0 = acc1_cnt; r0 = rx1_cnt;
      bus1.tx_data = 8'($urandom); bus1.three_wire = 1'b1; bus1.wr_len = '0; bus1.tx_valid = 1'b1;
      n = 0;
      while (acc1_cnt == a0 && n < 20) begin tick(); n++; end
      chk("accept1", acc1_cnt - a0, 1);
      bus1.tx_valid = 1'b0;
      n = 0;
      while (rx1_cnt == r0 && n < 100) begin tick(); n++; end
      chk("rx1_done", rx1_cnt - r0, 1);
      repeat (3) tick();
    end

    repeat (5) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI controller (initiator) for the team's SPI slave: generates scl and cs_n from the system clock and shifts one DATA_WIDTH-bit word per transaction, MSB first, in SPI mode 0 (CPOL=0, CPHA=0).
- Supports 4-wire mode: sdo to the slave's sdi, sdi_sdio as input.
- Supports 3-wire mode: sdi_sdio bidirectional, with master write bits first, then turnaround to read.
- Sits between a host-side valid/ready word interface and the SPI pins.

Parameters:
- DATA_WIDTH, 8: bits per transaction; must be >= 2.
- CLK_DIV, 2: clk cycles per scl half-period; must be >= 1. scl frequency = f_clk / (2*CLK_DIV).

Ports:
- clk       input   1   system clock; all logic on its rising edge.
- rst       input   1   synchronous, active-high reset.
- tx_data   input   DATA_WIDTH   word to shift out, MSB first.
- tx_valid  input   1   host request; transfer starts on tx_valid && tx_ready.
- tx_ready  output  1   high only in IDLE.
- three_wire input  1   1 = 3-wire (SDIO) mode; sampled with tx_data.
- wr_len    input   $clog2(DATA_WIDTH+1)   3-wire only: leading bits master drives on sdi_sdio; sampled with tx_data.
- rx_data   output  DATA_WIDTH   word sampled from sdi_sdio; valid when rx_valid=1, held until next completion.
- rx_valid  output  1   one-cycle pulse at transaction end.
- busy      output  1   high in every state except IDLE.
- scl       output  1   serial clock; idles low.
- cs_n      output  1   chip select, active low.
- sdo       output  1   serial data to the slave's sdi; 0 in 3-wire mode and when idle.
- sdi_sdio  inout   1   tri. 4-wire: never driven, input only. 3-wire: driven during write bits, else 1'bz.

Behaviour:
- All outputs registered.
- Reset values: scl=0, cs_n=1, sdo=0, sdi_sdio=z, tx_ready=1, busy=0, rx_valid=0, rx_data=0; state=IDLE.
- States:
  - IDLE: cs_n=1, tx_ready=1.
  - On accept at edge T, latch tx_data, three_wire and wr_len (clamped to DATA_WIDTH), then go to SHIFT.
  - SHIFT: from cycle T+1, cs_n=0 and the MSB is presented on the active data line.
  - Each bit lasts 2*CLK_DIV cycles: scl low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - Bit i rising edge at T+1+(2i+1)*CLK_DIV; falling edge at T+1+(2i+2)*CLK_DIV.
  - The next bit is presented on the same clk edge that drives scl low.
  - After the last falling edge at T+1+2*DATA_WIDTH*CLK_DIV, go to HOLD.
  - HOLD: cs_n=0, scl=0 for CLK_DIV cycles, then cs_n=1 and rx_valid=1 for one cycle, and rx_data updates on the same edge. Go to GAP.
  - GAP: cs_n=1 for CLK_DIV cycles (minimum deselect time); tx_ready=0. Then go to IDLE.
  - With DATA_WIDTH=8, CLK_DIV=2: cs_n low T+1, first scl rise T+3, last scl fall T+33, cs_n high and rx_valid at T+35, tx_ready high at T+37.
- Sampling: sdi_sdio is captured into the rx shift register on the clk edge that drives scl 0->1. Samples are shifted in MSB first.
- 3-wire mode:
  - Bits with index < wr_len (index 0 = MSB) are driven on sdi_sdio; sdo is held 0.
  - sdi_sdio is released to z on the falling-scl edge that ends bit wr_len-1.
  - wr_len=0: never driven. wr_len >= DATA_WIDTH: driven for the whole transfer, and released on entry to HOLD.
  - Write-phase samples, i.e. the master's own driven bits, still enter rx_data.
- tx_valid while busy is ignored; tx_data, three_wire and wr_len may change freely after accept.
- Reset mid-transfer: on the next edge cs_n=1, scl=0, sdi_sdio=z, state=IDLE, and no rx_valid pulse. rx_data is cleared to 0.
- scl never toggles while cs_n=1; cs_n never changes while scl=1.

Test Plan:
- 4-wire loopback: sdo tied to sdi_sdio, DATA_WIDTH=8, CLK_DIV=2, tx_data=8'hA5. Required: 8 scl pulses, cs_n low T+1..T+34, rx_valid at T+35 with rx_data=8'hA5, tx_ready at T+37.
- Slave model on sdi_sdio returning 8'h3C while tx_data=8'hFF. Required: sdo high for all bits, rx_data=8'h3C.
- 3-wire, wr_len=4, tx_data=8'hB0, slave model drives 4'h7 after turnaround. Required: sdi_sdio carries 1,0,1,1 then is z from bit-3 falling edge, rx_data=8'hB7, sdo stays 0.
- Back-to-back: tx_valid held high for 2 words (8'h01, 8'h80). Required: the second accept occurs exactly at tx_ready rise, with cs_n high for 2*CLK_DIV cycles between frames.
- rst asserted at the 3rd scl rising edge. Required: the next cycle has cs_n=1, scl=0, sdi_sdio=z, tx_ready=1 and rx_valid never pulses; a following transfer of 8'h5A completes correctly.
- CLK_DIV=1, wr_len=0, three_wire=1. Required: scl period of 2 clk cycles, sdi_sdio never driven, and protocol assertions (no scl toggle with cs_n high, busy == !tx_ready) hold throughout.
